// File: rtl/bus_bridge_req_arbiter.sv
// Round-robin arbiter sharing one bus bridge initiator channel between NUM_REQ requesters; one transaction in flight.
// Latency: upstream accept -> dn_req_valid next cycle; dn_resp accept -> up_resp_valid next cycle; 4 clocks minimum per transaction.
// Backpressure: up_req_ready only in IDLE (combinational, winner only); ISSUE/DELIVER hold payloads until the handshake.
//
// Ports: clk/rst_n (async active-low); up_req_* per-requester request valid/ready/payload;
//        up_resp_* one-hot response valid to the owner, shared payload; dn_req_*/dn_resp_* initiator side;
//        grant_id = owner of current/last transaction; busy = not IDLE; timeout_err = watchdog pulse.
// Optional build macro: BUS_BRIDGE_ARB_TIMEOUT_EN adds a response watchdog and late-response drain.

package bus_bridge_pkg;
    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  write_data;
        logic        is_write;
    } bus_bridge_req_t;

    typedef struct packed {
        logic [7:0] read_data;
        logic       is_write;
    } bus_bridge_resp_t;
endpackage

module bus_bridge_req_arbiter
    import bus_bridge_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              up_req_valid,
    output logic [NUM_REQ-1:0]              up_req_ready,
    input  bus_bridge_req_t [NUM_REQ-1:0]   up_req_payload,
    output logic [NUM_REQ-1:0]              up_resp_valid,
    input  logic [NUM_REQ-1:0]              up_resp_ready,
    output bus_bridge_resp_t                up_resp_payload,
    output logic                            dn_req_valid,
    input  logic                            dn_req_ready,
    output bus_bridge_req_t                 dn_req_payload,
    input  logic                            dn_resp_valid,
    output logic                            dn_resp_ready,
    input  bus_bridge_resp_t                dn_resp_payload,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            busy,
    output logic                            timeout_err
);

    localparam int IDW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("bus_bridge_req_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES at least 2");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, DELIVER} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   owner_q, owner_d;
    bus_bridge_req_t  req_q, req_d;
    bus_bridge_resp_t resp_q, resp_d;

    logic [IDW-1:0]   win_idx;
    logic             win_vld;
    logic [IDW:0]     cand_sum;
    logic             accept_blk;

`ifdef BUS_BRIDGE_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          drain_pending_q, drain_pending_d;
    logic          wd_fire;

    // Watchdog fires only if no response arrives in the terminal count cycle.
    assign wd_fire     = (state_q == WAIT_RESP) && !dn_resp_valid &&
                         (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign timeout_err = wd_fire;
    assign accept_blk  = drain_pending_q;
    // A pending drain keeps accepting responses so a late one cannot stall the initiator.
    assign dn_resp_ready = (state_q == WAIT_RESP) || drain_pending_q;
`else
    assign timeout_err   = 1'b0;
    assign accept_blk    = 1'b0;
    assign dn_resp_ready = (state_q == WAIT_RESP);
`endif

    // Round-robin search: walk offsets from high to low so the lowest offset from rr_ptr wins.
    always_comb begin
        win_idx  = '0;
        win_vld  = 1'b0;
        cand_sum = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand_sum = {1'b0, rr_ptr_q} + (IDW + 1)'(k);
            if (cand_sum >= (IDW + 1)'(NUM_REQ)) begin
                cand_sum = cand_sum - (IDW + 1)'(NUM_REQ);
            end
            if (up_req_valid[cand_sum[IDW-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand_sum[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        req_d        = req_q;
        resp_d       = resp_q;
        up_req_ready = '0;
`ifdef BUS_BRIDGE_ARB_TIMEOUT_EN
        cnt_d           = cnt_q;
        drain_pending_d = drain_pending_q;
        if (drain_pending_q && dn_resp_valid) begin
            drain_pending_d = 1'b0;
        end
`endif
        case (state_q)
            IDLE: begin
                if (win_vld && !accept_blk) begin
                    up_req_ready[win_idx] = 1'b1;
                    req_d    = up_req_payload[win_idx];
                    owner_d  = win_idx;
                    rr_ptr_d = (win_idx == IDW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (dn_req_ready) begin
                    state_d = WAIT_RESP;
`ifdef BUS_BRIDGE_ARB_TIMEOUT_EN
                    cnt_d = '0;
`endif
                end
            end
            WAIT_RESP: begin
                if (dn_resp_valid) begin
                    resp_d  = dn_resp_payload;
                    state_d = DELIVER;
                end
`ifdef BUS_BRIDGE_ARB_TIMEOUT_EN
                else if (wd_fire) begin
                    resp_d          = '{read_data: 8'hFF, is_write: req_q.is_write};
                    drain_pending_d = 1'b1;
                    state_d         = DELIVER;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DELIVER: begin
                if (up_resp_ready[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            req_q    <= '0;
            resp_q   <= '0;
`ifdef BUS_BRIDGE_ARB_TIMEOUT_EN
            cnt_q           <= '0;
            drain_pending_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            req_q    <= req_d;
            resp_q   <= resp_d;
`ifdef BUS_BRIDGE_ARB_TIMEOUT_EN
            cnt_q           <= cnt_d;
            drain_pending_q <= drain_pending_d;
`endif
        end
    end

    // All remaining outputs decode straight from flops, so reset clears them immediately.
    assign dn_req_valid    = (state_q == ISSUE);
    assign dn_req_payload  = req_q;
    assign up_resp_valid   = (state_q == DELIVER) ? (NUM_REQ'(1) << owner_q) : '0;
    assign up_resp_payload = resp_q;
    assign grant_id        = owner_q;
    assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_bus_bridge_req_arbiter.sv
module tb_bus_bridge_req_arbiter;
    import bus_bridge_pkg::*;

    localparam int N  = 2;
    localparam int TO = 16;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic [N-1:0]               up_req_valid = '0;
    logic [N-1:0]               up_req_ready;
    bus_bridge_req_t [N-1:0]    up_req_payload = '0;
    logic [N-1:0]               up_resp_valid;
    logic [N-1:0]               up_resp_ready = '0;
    bus_bridge_resp_t           up_resp_payload;
    logic                       dn_req_valid;
    logic                       dn_req_ready = 1'b0;
    bus_bridge_req_t            dn_req_payload;
    logic                       dn_resp_valid = 1'b0;
    logic                       dn_resp_ready;
    bus_bridge_resp_t           dn_resp_payload = '0;
    logic [$clog2(N)-1:0]       grant_id;
    logic                       busy;
    logic                       timeout_err;

    int checks = 0;
    int errors = 0;
    int model_ptr = 0;   // reference round-robin pointer: next requester to look at first

    bus_bridge_req_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .up_req_valid(up_req_valid), .up_req_ready(up_req_ready), .up_req_payload(up_req_payload),
        .up_resp_valid(up_resp_valid), .up_resp_ready(up_resp_ready), .up_resp_payload(up_resp_payload),
        .dn_req_valid(dn_req_valid), .dn_req_ready(dn_req_ready), .dn_req_payload(dn_req_payload),
        .dn_resp_valid(dn_resp_valid), .dn_resp_ready(dn_resp_ready), .dn_resp_payload(dn_resp_payload),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // First valid requester at or after ptr, wrapping modulo N.
    function automatic int ref_winner(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic bus_bridge_req_t rand_req();
        bus_bridge_req_t r;
        r.addr       = 16'($urandom);
        r.write_data = 8'($urandom);
        r.is_write   = 1'($urandom);
        return r;
    endfunction

    function automatic bus_bridge_resp_t rand_resp();
        bus_bridge_resp_t r;
        r.read_data = 8'($urandom);
        r.is_write  = 1'($urandom);
        return r;
    endfunction

    // One full transaction from IDLE back to IDLE with optional stalls on both handshakes.
    task automatic do_txn(input logic [N-1:0] vld, input bus_bridge_req_t [N-1:0] pls,
                          input bus_bridge_resp_t rsp, input int dstall, input int rstall,
                          output int win);
        int w;
        logic [N-1:0] own;
        up_req_payload = pls;
        up_req_valid   = vld;
        #1;
        w   = ref_winner(vld, model_ptr);
        own = N'(1) << w;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("req_ready_winner", 32'(up_req_ready), 32'(own));
        tick;
        model_ptr = (w + 1) % N;
        win = w;
        chk("issue_valid", 32'(dn_req_valid), 32'd1);
        chk("issue_payload", 32'(dn_req_payload), 32'(pls[w]));
        chk("grant_id", 32'(grant_id), 32'(w));
        chk("issue_busy", 32'(busy), 32'd1);
        chk("no_accept_issue", 32'(up_req_ready), 32'd0);
        for (int s = 0; s < dstall; s++) begin
            tick;
            chk("stall_valid", 32'(dn_req_valid), 32'd1);
            chk("stall_payload", 32'(dn_req_payload), 32'(pls[w]));
            chk("stall_no_accept", 32'(up_req_ready), 32'd0);
        end
        dn_req_ready = 1'b1;
        tick;
        dn_req_ready = 1'b0;
        chk("wait_req_drop", 32'(dn_req_valid), 32'd0);
        chk("wait_resp_ready", 32'(dn_resp_ready), 32'd1);
        chk("wait_no_resp", 32'(up_resp_valid), 32'd0);
        dn_resp_valid   = 1'b1;
        dn_resp_payload = rsp;
        tick;
        dn_resp_valid = 1'b0;
        chk("deliver_valid", 32'(up_resp_valid), 32'(own));
        chk("deliver_payload", 32'(up_resp_payload), 32'(rsp));
        chk("deliver_dn_ready", 32'(dn_resp_ready), 32'd0);
        // Non-owners say ready; the arbiter must keep waiting for the owner.
        up_resp_ready = ~own;
        for (int s = 0; s < rstall; s++) begin
            tick;
            chk("rstall_valid", 32'(up_resp_valid), 32'(own));
            chk("rstall_payload", 32'(up_resp_payload), 32'(rsp));
            chk("rstall_no_accept", 32'(up_req_ready), 32'd0);
        end
        up_resp_ready = '1;
        tick;
        up_resp_ready = '0;
        chk("back_idle", 32'(busy), 32'd0);
        chk("idle_no_resp", 32'(up_resp_valid), 32'd0);
        chk("no_timeout", 32'(timeout_err), 32'd0);
    endtask

    initial begin
        bus_bridge_req_t [N-1:0] pls;
        bus_bridge_resp_t rsp;
        int w;
        logic [N-1:0] v;

        // Reset state
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dn_req_valid", 32'(dn_req_valid), 32'd0);
        chk("rst_dn_resp_ready", 32'(dn_resp_ready), 32'd0);
        chk("rst_up_resp_valid", 32'(up_resp_valid), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_dn_payload", 32'(dn_req_payload), 32'd0);
        tick;
        rst_n = 1'b1;
        tick;

        // Contention: both held valid, grants must rotate 0,1,0,1
        for (int t = 0; t < 4; t++) begin
            pls[0] = rand_req();
            pls[1] = rand_req();
            do_txn(2'b11, pls, rand_resp(), 0, 0, w);
            chk("rr_order", 32'(w), 32'(t % 2));
        end
        up_req_valid = '0;

        // Single requester, directed payload, minimum latency
        pls[0] = '{addr: 16'h1234, write_data: 8'hA5, is_write: 1'b1};
        pls[1] = '0;
        rsp = '{read_data: 8'h00, is_write: 1'b1};
        do_txn(2'b01, pls, rsp, 0, 0, w);
        chk("single_grant", 32'(w), 32'd0);
        up_req_valid = '0;

        // Backpressure: 5 cycles on dn_req_ready, 3 cycles on up_resp_ready
        pls[0] = rand_req();
        pls[1] = rand_req();
        do_txn(2'b11, pls, rand_resp(), 5, 3, w);
        up_req_valid = '0;

        // Spurious response in IDLE
        dn_resp_valid   = 1'b1;
        dn_resp_payload = rand_resp();
        for (int s = 0; s < 3; s++) begin
            tick;
            chk("spur_dn_ready", 32'(dn_resp_ready), 32'd0);
            chk("spur_up_valid", 32'(up_resp_valid), 32'd0);
            chk("spur_busy", 32'(busy), 32'd0);
        end
        dn_resp_valid = 1'b0;

        // Randomized traffic
        for (int t = 0; t < 12; t++) begin
            v = N'($urandom_range(1, 3));
            pls[0] = rand_req();
            pls[1] = rand_req();
            do_txn(v, pls, rand_resp(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), w);
            up_req_valid = '0;
        end

        // Reset mid-transaction: make the pointer point at 1, start a txn, reset in WAIT_RESP
        pls[0] = rand_req();
        pls[1] = rand_req();
        do_txn(2'b01, pls, rand_resp(), 0, 0, w);
        up_req_payload = pls;
        up_req_valid   = 2'b11;
        tick;
        chk("pre_rst_grant", 32'(grant_id), 32'd1);
        up_req_valid = '0;
        dn_req_ready = 1'b1;
        tick;
        dn_req_ready = 1'b0;
        chk("pre_rst_wait", 32'(dn_resp_ready), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_dn_resp_ready", 32'(dn_resp_ready), 32'd0);
        chk("mid_rst_dn_req_valid", 32'(dn_req_valid), 32'd0);
        chk("mid_rst_up_resp_valid", 32'(up_resp_valid), 32'd0);
        chk("mid_rst_up_req_ready", 32'(up_req_ready), 32'd0);
        chk("mid_rst_grant", 32'(grant_id), 32'd0);
        chk("mid_rst_dn_payload", 32'(dn_req_payload), 32'd0);
        chk("mid_rst_up_payload", 32'(up_resp_payload), 32'd0);
        chk("mid_rst_timeout", 32'(timeout_err), 32'd0);
        model_ptr = 0;
        tick;
        rst_n = 1'b1;
        tick;
        pls[0] = rand_req();
        pls[1] = rand_req();
        do_txn(2'b11, pls, rand_resp(), 0, 0, w);
        chk("post_rst_first_grant", 32'(w), 32'd0);
        up_req_valid = '0;

`ifdef BUS_BRIDGE_ARB_TIMEOUT_EN
        // Watchdog: read with no response, then a late response must be drained
        pls[0] = rand_req();
        pls[0].is_write = 1'b0;
        up_req_payload = pls;
        up_req_valid   = 2'b01;
        tick;
        model_ptr = 1;
        up_req_valid = '0;
        dn_req_ready = 1'b1;
        tick;
        dn_req_ready = 1'b0;
        for (int i = 1; i <= TO; i++) begin
            chk("wd_pulse", 32'(timeout_err), (i == TO) ? 32'd1 : 32'd0);
            if (i < TO) tick;
        end
        tick;
        chk("wd_deliver_valid", 32'(up_resp_valid), 32'd1);
        chk("wd_deliver_payload", 32'(up_resp_payload), 32'h1FE);
        chk("wd_pulse_gone", 32'(timeout_err), 32'd0);
        chk("wd_drain_ready", 32'(dn_resp_ready), 32'd1);
        up_resp_ready = '1;
        tick;
        up_resp_ready = '0;
        up_req_payload[1] = rand_req();
        up_req_valid = 2'b10;
        #1;
        chk("drain_blocks_accept", 32'(up_req_ready), 32'd0);
        tick;
        chk("drain_blocks_accept2", 32'(up_req_ready), 32'd0);
        chk("drain_ready_idle", 32'(dn_resp_ready), 32'd1);
        dn_resp_valid   = 1'b1;
        dn_resp_payload = rand_resp();
        tick;
        dn_resp_valid = 1'b0;
        chk("drain_done_ready", 32'(dn_resp_ready), 32'd0);
        chk("drain_no_up_resp", 32'(up_resp_valid), 32'd0);
        pls[0] = rand_req();
        pls[1] = rand_req();
        do_txn(2'b10, pls, rand_resp(), 0, 0, w);
        chk("post_drain_grant", 32'(w), 32'd1);
        up_req_valid = '0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
